// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the CPU data-memory channel. One read or write
// request is accepted at a time, serviced from an internal word-addressed RAM
// after LATENCY cycles, and read data is returned on a valid/ready response
// channel. Completed reads and committed writes are counted.
//
// Parameters:
//   DEPTH_LOG2 : RAM holds 2**DEPTH_LOG2 32-bit words, index = Address[DEPTH_LOG2+1:2]
//   LATENCY    : accept edge to write commit / read-data valid, in edges (1..15)
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst             in   asynchronous active-low reset
//   Address         in   byte address (low two bits and bits above index ignored)
//   MemWrite        in   write request, held until accepted
//   Write_data      in   lane-aligned write data
//   Write_strb      in   byte enables, bit i covers bits [8i+7:8i]
//   MemRead         in   read request, held until accepted
//   Mem_Req_Ready   out  request channel ready (IDLE only)
//   Read_data       out  full word read from RAM
//   Read_data_Valid out  response valid (RESP only)
//   Read_data_Ready in   requester accepts response
//   rd_cnt          out  completed read responses (wraps)
//   wr_cnt          out  committed writes (wraps)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Merge new bytes into an old word under a byte-enable mask.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_e                  state_q,     state_d;
    logic [3:0]              cnt_q,       cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q,       idx_d;
    logic [31:0]             wdata_q,     wdata_d;
    logic [3:0]              wstrb_q,     wstrb_d;
    logic                    op_wr_q,     op_wr_d;
    logic                    req_ready_q, req_ready_d;
    logic [31:0]             rdata_q,     rdata_d;
    logic                    rvalid_q,    rvalid_d;
    logic [31:0]             rd_cnt_q,    rd_cnt_d;
    logic [31:0]             wr_cnt_q,    wr_cnt_d;
    logic                    mem_we_s;
    logic [31:0]             mem_rd_s;

    logic [31:0] mem [DEPTH];

    // Address bits outside the word index alias onto the same word.
    logic unused_addr_s;
    assign unused_addr_s = ^{Address[31:DEPTH_LOG2+2], Address[1:0]};

    assign mem_rd_s = mem[idx_q];

    // Next-state, request capture, response and counter logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        op_wr_d     = op_wr_q;
        req_ready_d = req_ready_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        mem_we_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                rvalid_d    = 1'b0;
                // Ready is only asserted one edge after reset release, so the
                // accept also requires the registered ready.
                if (req_ready_q && (MemRead || MemWrite)) begin
                    idx_d       = Address[DEPTH_LOG2+1:2];
                    wdata_d     = Write_data;
                    wstrb_d     = Write_strb;
                    op_wr_d     = MemWrite;   // write wins over a simultaneous read
                    cnt_d       = LAT_LOAD;
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                req_ready_d = 1'b0;
                // <= guards against a zero count locking the FSM.
                if (cnt_q <= 4'd1) begin
                    cnt_d = 4'd0;
                    if (op_wr_q) begin
                        mem_we_s    = 1'b1;
                        wr_cnt_d    = wr_cnt_q + 32'd1;
                        req_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        rdata_d  = mem_rd_s;
                        rvalid_d = 1'b1;
                        state_d  = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                req_ready_d = 1'b0;
                if (Read_data_Ready) begin
                    rvalid_d    = 1'b0;
                    req_ready_d = 1'b1;
                    rd_cnt_d    = rd_cnt_q + 32'd1;
                    state_d     = ST_IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b0;
                rvalid_d    = 1'b0;
                cnt_d       = 4'd0;
            end
        endcase
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            op_wr_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
            rd_cnt_q    <= 32'd0;
            wr_cnt_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            op_wr_q     <= op_wr_d;
            req_ready_q <= req_ready_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    // RAM write port; contents survive reset, and reset forces IDLE so a
    // pending write never commits.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[idx_q] <= merge_bytes(mem_rd_s, wdata_q, wstrb_q);
        end
    end

    assign Mem_Req_Ready   = req_ready_q;
    assign Read_data       = rdata_q;
    assign Read_data_Valid = rvalid_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data-memory channel.
- Accepts one read or write request at a time on the request channel (MemRead/MemWrite/Address/Write_data/Write_strb with Mem_Req_Ready).
- Services each request from an internal word-addressed RAM after a programmable latency.
- Returns load data on the response channel (Read_data/Read_data_Valid with Read_data_Ready).
- Sits between the CPU core and the simulation/FPGA memory map; keeps read/write counts for perf monitoring.

Parameters:
- DEPTH_LOG2, 10: RAM holds 2^DEPTH_LOG2 32-bit words; word index = Address[DEPTH_LOG2+1:2].
- LATENCY, 2: cycles from request-accept edge to write commit or read-data valid; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- Address  in  32  byte address; bits [1:0] and bits above the index are ignored (aliasing)
- MemWrite  in  1  write request, held until accepted
- Write_data  in  32  write data, lane-aligned
- Write_strb  in  4  byte enables; bit i writes bits [8i+7:8i]
- MemRead  in  1  read request, held until accepted
- Mem_Req_Ready  out  1  registered; high only in IDLE
- Read_data  out  32  registered full word read from RAM
- Read_data_Valid  out  1  registered; high only in RESP
- Read_data_Ready  in  1  CPU accepts read data
- rd_cnt  out  32  completed read responses, wraps at 2^32
- wr_cnt  out  32  committed writes, wraps at 2^32

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, Mem_Req_Ready=0, Read_data_Valid=0, Read_data=0, rd_cnt=0, wr_cnt=0, latency counter=0.
  - RAM contents are not cleared.
- After reset release: Mem_Req_Ready=1 from the first rising edge.
- Reset mid-operation: any pending write is dropped (RAM unchanged); any pending response is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Accept when Mem_Req_Ready=1 and (MemRead|MemWrite) at a rising edge.
  - On accept: latch word index, Write_data, Write_strb and op (write if MemWrite=1, else read). If both MemRead and MemWrite are high, treat as a write; no read response is produced.
  - On accept: load cnt=LATENCY, drop Mem_Req_Ready to 0, go to WAIT.
- WAIT:
  - cnt decrements each edge.
  - On the edge where cnt==1, write op: RAM[idx] updated under latched strobe only, wr_cnt+1, Mem_Req_Ready=1, go to IDLE. Write commits exactly LATENCY edges after the accept edge.
  - On the edge where cnt==1, read op: Read_data<=RAM[idx], Read_data_Valid=1, go to RESP. Valid rises exactly LATENCY edges after the accept edge.
  - Write_strb=4'b0000 still completes and counts; RAM unchanged.
- RESP:
  - Read_data and Read_data_Valid held stable until Read_data_Ready=1 at an edge.
  - On that edge: Read_data_Valid=0, Mem_Req_Ready=1, rd_cnt+1, go to IDLE.
  - Read_data keeps its last value after Valid falls.
  - Read_data_Ready high outside RESP has no effect.
- No new request is accepted in WAIT or RESP. Request inputs are ignored there; they are sampled only at the accept edge.
- Ordering: one outstanding request. A write commits before the next request is accepted, so a read following a write to the same word returns the new data.
- Read returns the full word; byte/half extraction is the requester's job.
- Minimum turnaround: IDLE→IDLE for a write takes LATENCY+1 cycles. A read takes LATENCY+1 cycles plus response-stall cycles.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=0 for 3 cycles, release, idle.
  - Required: Mem_Req_Ready=0 during reset and 1 one edge after release; Read_data_Valid=0; counters 0.
- Full write then read (LATENCY=2):
  - Stimulus: write Address=0x0000_0010, Write_data=0xDEADBEEF, strb=4'hF; then read 0x10 with Read_data_Ready=1.
  - Required: write accepted, Mem_Req_Ready low 2 cycles; read Valid rises 2 edges after accept; Read_data=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
- Byte strobes:
  - Stimulus: RAM[4]=0x11223344; write addr 0x12, data 0xAABBCCDD, strb=4'b0100; read 0x10.
  - Required: Read_data=0x11BB3344. Repeat with strb=0: data unchanged, wr_cnt still increments.
- Response backpressure:
  - Stimulus: read with Read_data_Ready=0 for 5 cycles after Valid, then 1; toggle MemWrite during the stall.
  - Required: Valid and Read_data stable throughout stall; Mem_Req_Ready=0; stray MemWrite ignored; rd_cnt +1 only at handshake.
- Priority/aliasing:
  - Stimulus: MemRead=MemWrite=1 at 0x8, data 0x5; then read 0x8+(4<<DEPTH_LOG2).
  - Required: no Valid for the dual request; alias read returns 0x5; wr_cnt +1.
- Reset mid-op:
  - Stimulus: assert rst=0 during WAIT of a write to 0x20 (prior 0x0), and separately during RESP.
  - Required: RAM[8] still 0x0; Read_data_Valid=0 immediately (async); FSM in IDLE; counters 0.
